// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion plus multiply/divide freeze.
// Outputs are combinational from the ID/EXE fields and the MDU wait state; reset forces a free-running pipe.
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs_raddr,
   input  logic [4:0]  id_rt_raddr,
   input  logic        id_rs_used,
   input  logic        id_rt_used,
   input  logic        id_mul_ena,
   input  logic        id_div_ena,
   input  logic [4:0]  exe_rf_waddr,
   input  logic        exe_rf_wena,
   input  logic        exe_is_load,
   input  logic        div_done,
   output logic        pc_wena,
   output logic        if_id_wena,
   output logic        id_exe_wena,
   output logic        id_exe_bubble,
   output logic        div_start,
   output logic        mdu_busy,
   output logic        mdu_timeout,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

   localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LAST = 6'(DIV_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        mdu_timeout_q, mdu_timeout_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;

   logic load_use;
   logic pc_en, if_id_en, id_exe_en, bubble_c, div_go;

   assign load_use = exe_is_load & exe_rf_wena & (exe_rf_waddr != 5'd0) &
                     ((id_rs_used & (id_rs_raddr == exe_rf_waddr)) |
                      (id_rt_used & (id_rt_raddr == exe_rf_waddr)));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mdu_timeout_d = mdu_timeout_q;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_exe_en     = 1'b1;
      bubble_c      = 1'b0;
      div_go        = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_use) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               bubble_c = 1'b1;
            end else if (id_div_ena) begin
               div_go  = 1'b1;
               cnt_d   = 6'd0;
               state_d = DIV_WAIT;
            end else if (id_mul_ena && (MUL_CYCLES > 1)) begin
               cnt_d   = MUL_LOAD;
               state_d = MUL_WAIT;
            end
         end
         MUL_WAIT: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_exe_en = 1'b0;
            cnt_d     = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = IDLE;
            end
         end
         DIV_WAIT: begin
            // Divider answer wins over a timeout landing in the same cycle.
            if (div_done) begin
               state_d = IDLE;
            end else if (cnt_q == DIV_LAST) begin
               state_d       = IDLE;
               mdu_timeout_d = 1'b1;
            end else begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_exe_en = 1'b0;
               cnt_d     = cnt_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   assign pc_wena       = rst | pc_en;
   assign if_id_wena    = rst | if_id_en;
   assign id_exe_wena   = rst | id_exe_en;
   assign id_exe_bubble = ~rst & bubble_c;
   assign div_start     = ~rst & div_go;
   assign mdu_busy      = ~rst & (state_q != IDLE);
   assign mdu_timeout   = mdu_timeout_q;
   assign stall_cycles  = stall_cycles_q;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_wena && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 6'd0;
         mdu_timeout_q  <= 1'b0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mdu_timeout_q  <= mdu_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int MUL_CYCLES  = 4;
   localparam int DIV_TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs_raddr, id_rt_raddr, exe_rf_waddr;
   logic        id_rs_used, id_rt_used, id_mul_ena, id_div_ena;
   logic        exe_rf_wena, exe_is_load, div_done;
   logic        pc_wena, if_id_wena, id_exe_wena, id_exe_bubble;
   logic        div_start, mdu_busy, mdu_timeout;
   logic [15:0] stall_cycles;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .id_rs_raddr(id_rs_raddr), .id_rt_raddr(id_rt_raddr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_mul_ena(id_mul_ena), .id_div_ena(id_div_ena),
      .exe_rf_waddr(exe_rf_waddr), .exe_rf_wena(exe_rf_wena),
      .exe_is_load(exe_is_load), .div_done(div_done),
      .pc_wena(pc_wena), .if_id_wena(if_id_wena), .id_exe_wena(id_exe_wena),
      .id_exe_bubble(id_exe_bubble), .div_start(div_start), .mdu_busy(mdu_busy),
      .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: which unit the pipe is frozen for, and how long.
   int m_kind;      // 0 = free, 1 = multiply, 2 = divide
   int m_left;      // multiply frozen cycles still to come
   int m_elapsed;   // divide cycles already waited
   int m_stalls;
   bit m_timeout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Evaluate one cycle: inputs already driven just after posedge.
   task automatic cycle();
      bit lu, release_div;
      bit e_pc, e_ifid, e_idexe, e_bub, e_ds, e_busy;
      #4;
      lu = exe_is_load && exe_rf_wena && (exe_rf_waddr != 0) &&
           ((id_rs_used && id_rs_raddr == exe_rf_waddr) ||
            (id_rt_used && id_rt_raddr == exe_rf_waddr));
      if (rst) begin
         m_kind = 0; m_left = 0; m_elapsed = 0; m_stalls = 0; m_timeout = 0;
      end
      e_pc = 1; e_ifid = 1; e_idexe = 1; e_bub = 0; e_ds = 0;
      release_div = (m_kind == 2) && (div_done || m_elapsed == DIV_TIMEOUT - 1);
      if (!rst) begin
         if (m_kind == 0 && lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
         end else if (m_kind == 0) begin
            e_ds = id_div_ena;
         end else if (m_kind == 1 || !release_div) begin
            e_pc = 0; e_ifid = 0; e_idexe = 0;
         end
      end
      e_busy = !rst && (m_kind != 0);

      check("pc_wena", pc_wena, e_pc);
      check("if_id_wena", if_id_wena, e_ifid);
      check("id_exe_wena", id_exe_wena, e_idexe);
      check("bubble", id_exe_bubble, e_bub);
      check("div_start", div_start, e_ds);
      check("mdu_busy", mdu_busy, e_busy);
      check("stall_cycles", stall_cycles, m_stalls);
      check("mdu_timeout", mdu_timeout, m_timeout);

      if (!rst) begin
         if (!e_pc && m_stalls < 65535) m_stalls++;
         case (m_kind)
            0: if (!lu) begin
               if (id_div_ena) begin
                  m_kind = 2; m_elapsed = 0;
               end else if (id_mul_ena && MUL_CYCLES > 1) begin
                  m_kind = 1; m_left = MUL_CYCLES - 1;
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) m_kind = 0;
            end
            default: begin
               if (release_div) begin
                  if (!div_done) m_timeout = 1;
                  m_kind = 0;
               end else begin
                  m_elapsed++;
               end
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                        input bit rtu, input bit mul, input bit dv, input bit [4:0] wa,
                        input bit we, input bit ld, input bit done);
      rst = r; id_rs_raddr = rs; id_rs_used = rsu; id_rt_raddr = rt; id_rt_used = rtu;
      id_mul_ena = mul; id_div_ena = dv; exe_rf_waddr = wa; exe_rf_wena = we;
      exe_is_load = ld; div_done = done;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, 2, 0, 0, 0, 3, 0, 0, 0);
   endtask

   initial begin
      m_kind = 0; m_left = 0; m_elapsed = 0; m_stalls = 0; m_timeout = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Reset forces enables high even with a load-use and mdu requests present.
      drive(1, 5, 1, 0, 0, 1, 1, 5, 1, 1, 1);
      drive(1, 5, 1, 0, 0, 1, 1, 5, 1, 1, 1);

      // Load-use on rs: one bubble cycle.
      drive(0, 5, 1, 0, 0, 0, 0, 5, 1, 1, 0);
      drive(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("lu_stall_count", stall_cycles, 1);
      // Load-use on rt, rs unused.
      drive(0, 5, 0, 7, 1, 0, 0, 7, 1, 1, 0);
      // Load to $0: no stall.
      drive(0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
      // Non-load producer: no stall.
      drive(0, 6, 1, 0, 0, 0, 0, 6, 1, 0, 0);
      check("no_stall_count", stall_cycles, 2);

      // Multiply: 3 frozen cycles.
      drive(0, 1, 0, 2, 0, 1, 0, 3, 0, 0, 0);
      drive(0, 9, 1, 0, 0, 0, 0, 9, 1, 1, 1);  // hazard and div_done ignored while frozen
      idle(4);
      check("mul_stall_count", stall_cycles, 5);

      // Divide answered 10 cycles after start.
      drive(0, 1, 0, 2, 0, 0, 1, 3, 0, 0, 0);
      idle(10);
      drive(0, 1, 0, 2, 0, 0, 0, 3, 0, 0, 1);
      idle(2);
      check("div_stall_count", stall_cycles, 15);
      check("div_no_timeout", mdu_timeout, 0);

      // Divide never answered: timeout after 39 frozen cycles.
      drive(0, 1, 0, 2, 0, 0, 1, 3, 0, 0, 0);
      idle(42);
      drive(0, 1, 0, 2, 0, 0, 0, 3, 0, 0, 1);
      idle(2);
      check("timeout_flag", mdu_timeout, 1);
      check("timeout_stall_count", stall_cycles, 54);

      // Reset in the 5th divide wait cycle, then mul+div together.
      drive(0, 1, 0, 2, 0, 0, 1, 3, 0, 0, 0);
      idle(4);
      drive(1, 1, 0, 2, 0, 1, 1, 3, 0, 0, 0);
      drive(0, 1, 0, 2, 0, 1, 1, 3, 0, 0, 0);
      check("post_rst_timeout", mdu_timeout, 0);
      idle(3);
      check("post_rst_stalls", stall_cycles, 3);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 299) == 0),
               5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 29) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: fixed multiplier latency in cycles; legal range 1..63.
REQ-002 Parameter DIV_TIMEOUT, default 40: maximum divide wait in cycles; legal range 2..63.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 id_rs_raddr, id_rt_raddr  in  5 each  source register addresses of the ID instruction.
REQ-006 id_rs_used, id_rt_used  in  1 each  ID instruction actually reads rs / rt.
REQ-007 id_mul_ena, id_div_ena  in  1 each  ID instruction is a multiply / divide.
REQ-008 exe_rf_waddr  in  5  destination register of the EXE instruction.
REQ-009 exe_rf_wena  in  1  EXE instruction writes the register file.
REQ-010 exe_is_load  in  1  EXE instruction is a memory load.
REQ-011 div_done  in  1  one-cycle pulse from the divider when the result is ready.
REQ-012 pc_wena, if_id_wena  out  1 each  write enables for the PC and the IF/ID register.
REQ-013 id_exe_wena  out  1  write enable for the ID/EXE register.
REQ-014 id_exe_bubble  out  1  drives the ID/EXE register clear (stall) input; inserts a NOP.
REQ-015 div_start  out  1  one-cycle divider start pulse.
REQ-016 mdu_busy  out  1  high while the FSM is not in IDLE.
REQ-017 mdu_timeout  out  1  sticky error flag: divider failed to answer.
REQ-018 stall_cycles  out  16  saturating count of cycles with pc_wena=0.

Function
REQ-019 The FSM SHALL have three states: IDLE, MUL_WAIT, DIV_WAIT; it holds a 6-bit cycle counter cnt.
REQ-020 load_use SHALL be defined as exe_is_load & exe_rf_wena & (exe_rf_waddr!=0) & ((id_rs_used & id_rs_raddr==exe_rf_waddr) | (id_rt_used & id_rt_raddr==exe_rf_waddr)).
REQ-021 In IDLE with load_use, the block SHALL drive pc_wena=0, if_id_wena=0, id_exe_wena=1, id_exe_bubble=1, div_start=0, and the state SHALL not change.
REQ-022 In IDLE without load_use, the block SHALL drive pc_wena=if_id_wena=id_exe_wena=1 and id_exe_bubble=0.
REQ-023 In IDLE without load_use and with id_div_ena=1, the block SHALL assert div_start for that cycle, load cnt=0 and go to DIV_WAIT; div takes priority when id_mul_ena=1 is also asserted.
REQ-024 In IDLE without load_use, with id_mul_ena=1 and id_div_ena=0, the block SHALL load cnt=MUL_CYCLES-1 and go to MUL_WAIT; if MUL_CYCLES=1 it SHALL stay in IDLE.
REQ-025 In MUL_WAIT with cnt!=0: all three write enables SHALL be 0, bubble=0, and cnt SHALL decrement.
REQ-026 In MUL_WAIT when cnt==1, the next cycle SHALL be IDLE.
REQ-027 In DIV_WAIT without div_done: all three write enables SHALL be 0, bubble=0, and cnt SHALL increment.
REQ-028 In DIV_WAIT with div_done: the enables SHALL be 1 in that same cycle (Mealy release), and the next state SHALL be IDLE.
REQ-029 In DIV_WAIT, if cnt reaches DIV_TIMEOUT-1 without div_done: the enables SHALL be 1 that cycle, the next state SHALL be IDLE, and mdu_timeout SHALL be set.
REQ-030 mdu_timeout SHALL clear only on reset.
REQ-031 div_done SHALL be ignored in IDLE and in MUL_WAIT.
REQ-032 ID hazard inputs SHALL be ignored in the WAIT states; they are re-evaluated in the first IDLE cycle.
REQ-033 stall_cycles SHALL increment on each cycle with pc_wena=0 and saturate at 16'hFFFF without wrapping.
REQ-034 div_start SHALL never be asserted for two consecutive cycles.

Reset
REQ-035 While rst=1, the block SHALL hold state=IDLE, cnt=0, mdu_timeout=0 and stall_cycles=0.
REQ-036 While rst=1, the outputs SHALL be pc_wena=if_id_wena=id_exe_wena=1, bubble=0, div_start=0 and mdu_busy=0, regardless of the other inputs.
REQ-037 A reset asserted mid-MUL_WAIT or mid-DIV_WAIT SHALL abort the operation immediately (asynchronously); no stale div_start or stall SHALL follow reset release.

Verification
REQ-038 Load-use: EXE lw $5 (exe_is_load=1, waddr=5), ID reads rs=5 -> exactly 1 cycle with pc_wena=0 and bubble=1; the next cycle has enables=1; stall_cycles=1.
REQ-039 Load to $0: waddr=0, rs=0 -> no stall; bubble stays 0.
REQ-040 MUL with MUL_CYCLES=4: id_mul_ena pulse -> issue cycle has enables=1, then 3 frozen cycles; mdu_busy is high for 3 cycles; stall_cycles=3.
REQ-041 DIV: id_div_ena pulse, div_done 10 cycles after div_start -> single div_start pulse, 10 frozen cycles, release in the div_done cycle; mdu_timeout stays 0.
REQ-042 DIV with div_done never asserted (DIV_TIMEOUT=40) -> release after 39 frozen cycles and mdu_timeout=1; a later div_done is ignored.
REQ-043 rst pulsed in the 5th DIV_WAIT cycle, then id_mul_ena and id_div_ena both high with load_use=0 -> state=IDLE and enables=1 during reset; after release, div_start is asserted (div priority); stall_cycles restarts from 0.
